// File: rtl/mem_controller_if.sv
// Request and SRAM-control bundle between the dot-product sequencer and its SRAM bank.
// The master side issues phase requests; the slave side drives per-SRAM enables, addresses and the count.
interface mem_controller_if #(
    parameter int Addr_Width       = 4,
    parameter int Nums_SRAM        = 3,
    parameter int bits_Computation = 4
);
    logic                              Computing;
    logic                              load_from_file;
    logic [Nums_SRAM-1:0]              Mem_Clear;
    logic [Nums_SRAM-1:0]              En_Chip_Select;
    logic [Nums_SRAM-1:0]              En_Write;
    logic [Nums_SRAM-1:0]              En_Read;
    logic [Nums_SRAM*Addr_Width-1:0]   Addr_Read;
    logic [Nums_SRAM*Addr_Width-1:0]   Addr_Write;
    logic [bits_Computation-1:0]       test;

    modport master (
        output Computing, load_from_file,
        input  Mem_Clear, En_Chip_Select, En_Write, En_Read, Addr_Read, Addr_Write, test
    );

    modport slave (
        input  Computing, load_from_file,
        output Mem_Clear, En_Chip_Select, En_Write, En_Read, Addr_Read, Addr_Write, test
    );
endinterface

// File: rtl/mem_controller.sv
// Address/enable sequencer for the dot-product SRAM bank: fills operand SRAMs, then streams
// operand reads with a one-cycle-delayed result write into the last SRAM.
//
// mode          | meaning
// MODE_IDLE     | no request; only a pending result write may be issued
// MODE_LOAD     | fill operand SRAMs at wr_idx until the last word is written
// MODE_COMPUTE  | read operand SRAMs at rd_idx, count computations
// MODE_CLEAR    | Mem_reset: clear all SRAMs, suppress access, freeze state
module mem_controller #(
    parameter int Addr_Width       = 4,
    parameter int Nums_SRAM        = 3,
    parameter int bits_Computation = 4
) (
    input  logic clk,
    input  logic Mem_reset,
    input  logic Comp_reset,
    input  logic Mem_Index_reset,
    mem_controller_if.slave bus
);
    localparam int Ram_Depth        = 1 << Addr_Width;
    localparam int Nums_Computation = 1 << bits_Computation;
    localparam logic [Addr_Width-1:0]       LAST_ADDR = Addr_Width'(Ram_Depth - 1);
    localparam logic [bits_Computation-1:0] LAST_COMP = bits_Computation'(Nums_Computation - 1);
    localparam int RES = Nums_SRAM - 1;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_LOAD,
        MODE_COMPUTE,
        MODE_CLEAR
    } mode_t;

    mode_t                       mode;
    logic [Addr_Width-1:0]       wr_idx;
    logic [Addr_Width-1:0]       rd_idx;
    logic [Addr_Width-1:0]       pend_addr;
    logic [bits_Computation-1:0] cnt;
    logic                        load_done;
    logic                        comp_done;
    logic                        pend;
    logic                        write_op;
    logic                        issue_read;

    always_comb begin
        mode = MODE_IDLE;
        if (Mem_reset)
            mode = MODE_CLEAR;
        else if (bus.load_from_file)
            mode = MODE_LOAD;
        else if (bus.Computing)
            mode = MODE_COMPUTE;
    end

    assign write_op   = (mode == MODE_LOAD) && !load_done;
    assign issue_read = (mode == MODE_COMPUTE) && !comp_done;

    // Index/computation resets are applied last so they win over any advance in the same cycle.
    always_ff @(posedge clk) begin
        if (mode != MODE_CLEAR) begin
            if (write_op) begin
                if (wr_idx == LAST_ADDR)
                    load_done <= 1'b1;
                else
                    wr_idx <= wr_idx + 1'b1;
            end
            if (issue_read) begin
                rd_idx    <= rd_idx + 1'b1;
                pend_addr <= rd_idx;
                if (cnt == LAST_COMP)
                    comp_done <= 1'b1;
                else
                    cnt <= cnt + 1'b1;
            end
            pend <= issue_read;
        end
        if (Mem_Index_reset) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            pend_addr <= '0;
            load_done <= 1'b0;
            pend      <= 1'b0;
        end
        if (Comp_reset) begin
            cnt       <= '0;
            comp_done <= 1'b0;
            pend      <= 1'b0;
        end
    end

    always_comb begin
        bus.Mem_Clear      = '0;
        bus.En_Chip_Select = '0;
        bus.En_Write       = '0;
        bus.En_Read        = '0;
        bus.Addr_Read      = '0;
        bus.Addr_Write     = '0;
        bus.test           = cnt;
        if (mode == MODE_CLEAR) begin
            bus.Mem_Clear = '1;
        end else begin
            for (int i = 0; i < RES; i++) begin
                if (write_op) begin
                    bus.En_Chip_Select[i]                       = 1'b1;
                    bus.En_Write[i]                             = 1'b1;
                    bus.Addr_Write[i*Addr_Width +: Addr_Width] = wr_idx;
                end
                if (issue_read) begin
                    bus.En_Chip_Select[i]                      = 1'b1;
                    bus.En_Read[i]                             = 1'b1;
                    bus.Addr_Read[i*Addr_Width +: Addr_Width] = rd_idx;
                end
            end
            if (pend) begin
                bus.En_Chip_Select[RES]                       = 1'b1;
                bus.En_Write[RES]                             = 1'b1;
                bus.Addr_Write[RES*Addr_Width +: Addr_Width] = pend_addr;
            end
        end
    end
endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a word-count/queue model predicts every output each cycle,
// and a few hand-computed literals pin the model at key points.
module tb_mem_controller;
    localparam int AW = 4;
    localparam int NS = 3;
    localparam int BC = 4;
    localparam int DEPTH = 16;
    localparam int NCOMP = 16;

    logic clk;
    logic Mem_reset, Comp_reset, Mem_Index_reset;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 0;

    mem_controller_if #(.Addr_Width(AW), .Nums_SRAM(NS), .bits_Computation(BC)) bus ();

    mem_controller #(.Addr_Width(AW), .Nums_SRAM(NS), .bits_Computation(BC)) dut (
        .clk(clk),
        .Mem_reset(Mem_reset),
        .Comp_reset(Comp_reset),
        .Mem_Index_reset(Mem_Index_reset),
        .bus(bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: words loaded so far, computations done so far, next read address,
    // and the queue of result writes still owed.
    int ld_n = 0;
    int rd_n = 0;
    int rd_next = 0;
    int rq[$];
    bit do_load, do_read;
    logic [NS-1:0]    e_clr, e_cs, e_wr, e_rd;
    logic [NS*AW-1:0] e_aw, e_ar;
    logic [BC-1:0]    e_t;

    // Inputs change just after posedge, so at negedge they describe the coming edge.
    always @(negedge clk) begin
        e_clr = '0; e_cs = '0; e_wr = '0; e_rd = '0; e_aw = '0; e_ar = '0;
        do_load = !Mem_reset && bus.load_from_file && (ld_n < DEPTH);
        do_read = !Mem_reset && !bus.load_from_file && bus.Computing && (rd_n < NCOMP);
        e_t = (rd_n == NCOMP) ? BC'(NCOMP - 1) : BC'(rd_n);
        if (Mem_reset) begin
            e_clr = '1;
        end else begin
            for (int i = 0; i < NS - 1; i++) begin
                if (do_load) begin
                    e_cs[i] = 1'b1; e_wr[i] = 1'b1; e_aw[i*AW +: AW] = AW'(ld_n);
                end
                if (do_read) begin
                    e_cs[i] = 1'b1; e_rd[i] = 1'b1; e_ar[i*AW +: AW] = AW'(rd_next);
                end
            end
            if (rq.size() > 0) begin
                e_cs[NS-1] = 1'b1; e_wr[NS-1] = 1'b1; e_aw[(NS-1)*AW +: AW] = AW'(rq[0]);
            end
        end
        if (check_en) begin
            chk("Mem_Clear",      32'(bus.Mem_Clear),      32'(e_clr));
            chk("En_Chip_Select", 32'(bus.En_Chip_Select), 32'(e_cs));
            chk("En_Write",       32'(bus.En_Write),       32'(e_wr));
            chk("En_Read",        32'(bus.En_Read),        32'(e_rd));
            chk("Addr_Read",      32'(bus.Addr_Read),      32'(e_ar));
            chk("Addr_Write",     32'(bus.Addr_Write),     32'(e_aw));
            chk("test",           32'(bus.test),           32'(e_t));
        end
        if (!Mem_reset) begin
            if (do_load) ld_n++;
            if (rq.size() > 0) void'(rq.pop_front());
            if (do_read) begin
                rq.push_back(rd_next);
                rd_next = (rd_next + 1) % DEPTH;
                rd_n++;
            end
        end
        if (Mem_Index_reset) begin
            ld_n = 0; rd_next = 0; rq.delete();
        end
        if (Comp_reset) begin
            rd_n = 0; rq.delete();
        end
    end

    task automatic drive(input bit l, input bit c, input bit mr, input bit cr, input bit ir);
        @(posedge clk);
        #1;
        bus.load_from_file = l;
        bus.Computing      = c;
        Mem_reset          = mr;
        Comp_reset         = cr;
        Mem_Index_reset    = ir;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_from_file = 1'b0;
        bus.Computing      = 1'b0;
        Mem_reset          = 1'b1;
        Comp_reset         = 1'b1;
        Mem_Index_reset    = 1'b1;

        // full reset edge, then everything idle
        drive(0, 0, 0, 0, 0);
        check_en = 1;
        @(negedge clk);
        chk("rst_clear", 32'(bus.Mem_Clear), 32'h0);
        chk("rst_cs",    32'(bus.En_Chip_Select), 32'h0);
        chk("rst_test",  32'(bus.test), 32'h0);

        // load: 16 writes then a quiet 17th cycle
        for (int k = 0; k < 17; k++) begin
            drive(1, 0, 0, 0, 0);
            @(negedge clk);
            if (k == 5)  chk("load_addr5", 32'(bus.Addr_Write), 32'h055);
            if (k == 16) chk("load_done_wr", 32'(bus.En_Write), 32'h0);
            if (k == 16) chk("load_done_cs", 32'(bus.En_Chip_Select), 32'h0);
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // compute 10, clear for 2 with Computing held, then finish the run
        for (int k = 0; k < 10; k++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("mr_clear", 32'(bus.Mem_Clear), 32'h7);
        chk("mr_test",  32'(bus.test), 32'd10);
        chk("mr_cs",    32'(bus.En_Chip_Select), 32'h0);
        drive(0, 1, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0, 0);
            @(negedge clk);
            if (k == 0) chk("resume_res_addr", 32'(bus.Addr_Write), 32'h900);
            if (k == 6) chk("last_res_wr",   32'(bus.En_Write), 32'h4);
            if (k == 6) chk("last_res_addr", 32'(bus.Addr_Write), 32'hF00);
            if (k == 7) chk("done_test", 32'(bus.test), 32'd15);
            if (k == 7) chk("done_cs",   32'(bus.En_Chip_Select), 32'h0);
        end

        // counters and indices cleared, then load and compute requested together
        drive(0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0);
            @(negedge clk);
            if (k == 2) chk("both_rd",   32'(bus.En_Read), 32'h0);
            if (k == 2) chk("both_addr", 32'(bus.Addr_Write), 32'h022);
            if (k == 2) chk("both_test", 32'(bus.test), 32'h0);
        end

        // fresh computation restarts at address 0
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 0, 0);
            @(negedge clk);
            if (k == 0) chk("restart_ar", 32'(bus.Addr_Read), 32'h000);
            if (k == 0) chk("restart_rd", 32'(bus.En_Read), 32'h3);
            if (k == 1) chk("restart_ar1", 32'(bus.Addr_Read), 32'h011);
            if (k == 1) chk("restart_res", 32'(bus.Addr_Write), 32'h000);
        end

        // Computing dropped: pending result write drains, counters freeze
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_res_wr",   32'(bus.En_Write), 32'h4);
        chk("idle_res_addr", 32'(bus.Addr_Write), 32'h400);
        chk("idle_test",     32'(bus.test), 32'd5);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_quiet", 32'(bus.En_Chip_Select), 32'h0);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("resume_ar", 32'(bus.Addr_Read), 32'h055);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
